spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 clk  in  1  system clock; all logic on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; begins a read burst; ignored while busy=1.
REQ-004 addr  in  24  flash byte address; sampled on start.
REQ-005 len  in  16  byte count; sampled on start; 0 means no transfer.
REQ-006 busy  out  1  high from the cycle after an accepted start until done.
REQ-007 done  out  1  one-cycle pulse when the burst ends and CS is released.
REQ-008 data_out  out  8  received byte; valid when data_valid=1.
REQ-009 data_valid  out  1  one-cycle pulse per delivered byte.
REQ-010 sink_ready  in  1  consumer may accept a byte; when low, the next read strobe is withheld.
REQ-011 flash_cs_n  out  1  flash chip select, active low.
REQ-012 spi_enviar  out  1  send strobe to the SPI byte engine.
REQ-013 spi_recibir  out  1  receive strobe to the SPI byte engine.
REQ-014 spi_tx  out  8  byte presented to the engine's din; stable while spi_enviar=1.
REQ-015 spi_rx  in  8  engine dout; the byte from the previous transfer, valid the cycle after spi_recibir.
REQ-016 spi_busy  in  1  engine transfer-in-progress flag.

Function
REQ-017 States: IDLE, CS_SETUP, CMD, ADDR2, ADDR1, ADDR0, PRIME, READ, TAIL, CS_HOLD.
REQ-018 Each strobe is high for exactly one cycle, followed by at least one low cycle; the engine edge-detects.
REQ-019 After a strobe, the FSM waits one cycle, then waits until spi_busy=0 before issuing the next strobe.
REQ-020 IDLE: start with len!=0 -> CS_SETUP with flash_cs_n=0; start with len=0 -> done pulse next cycle; CS stays high and busy stays 0.
REQ-021 CS_SETUP holds CS low for 2 cycles, then -> CMD.
REQ-022 CMD sends 0x03; ADDR2, ADDR1 and ADDR0 send addr[23:16], addr[15:8] and addr[7:0], in that order.
REQ-023 PRIME issues one spi_recibir whose returned byte is discarded; this starts the first data transfer.
REQ-024 READ: when sink_ready=1 and the engine is idle, issue spi_recibir; on the following cycle, drive data_out=spi_rx with data_valid=1 and decrement the remaining count.
REQ-025 When the remaining count reaches 0, go to TAIL; TAIL waits for spi_busy=0 (completing the trailing dummy transfer), then -> CS_HOLD.
REQ-026 CS_HOLD raises flash_cs_n, waits 2 cycles, pulses done, and returns to IDLE.
REQ-027 Exactly len data_valid pulses are produced per burst; len=16'hFFFF delivers 65535 bytes with no wrap.
REQ-028 start asserted while busy=1 has no effect; addr and len are not resampled.
REQ-029 sink_ready low only delays strobes; it never drops or duplicates bytes.

Reset
REQ-030 rst=1 forces: state IDLE, flash_cs_n=1, busy=0, done=0, data_valid=0, spi_enviar=0, spi_recibir=0, data_out=8'h00, spi_tx=8'hFF, count=0.
REQ-031 rst mid-burst deasserts CS in the next cycle and emits no done; the engine finishes its current byte unobserved.

Configuration
REQ-032 Macro SPI_FLASH_FAST_READ_EN: when defined, CMD sends 0x0B and a DUMMY state between ADDR0 and PRIME sends 0xFF; when undefined, CMD sends 0x03 and no DUMMY state exists.

Structure
REQ-033 Package spi_flash_pkg holds command constants (CMD_READ=8'h03, CMD_FAST_READ=8'h0B), the state enum, CS_SETUP_CYCLES=2 and CS_HOLD_CYCLES=2.
REQ-034 No sub-module; the SPI byte engine is instantiated beside this block at the parent level.

Verification
REQ-035 start, addr=24'h012345, len=4, flash model returning A0..A3 -> MOSI 03 01 23 45; data_out A0,A1,A2,A3; one done pulse; CS low for the whole burst.
REQ-036 start, len=0 -> done exactly one cycle later; flash_cs_n never low; no strobes issued.
REQ-037 len=3, sink_ready low 50 cycles after the first byte -> still 3 data_valid pulses in order; no strobe while sink_ready=0.
REQ-038 rst asserted during ADDR1 -> flash_cs_n=1 next cycle; no done; a new start then completes normally.
REQ-039 SPI_FLASH_FAST_READ_EN defined, addr=24'h000010, len=2 -> MOSI 0B 00 00 10 FF; two bytes delivered.
REQ-040 start pulsed again mid-burst with different addr and len -> ignored; the original burst completes unchanged.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and types for the SPI flash read sequencer (option macro: SPI_FLASH_FAST_READ_EN)
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] DUMMY_BYTE    = 8'hFF;

  localparam int CS_SETUP_CYCLES = 2;
  localparam int CS_HOLD_CYCLES  = 2;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_OPCODE = CMD_FAST_READ;
`else
  localparam logic [7:0] READ_OPCODE = CMD_READ;
`endif

  typedef enum logic [3:0] {
    IDLE,
    CS_SETUP,
    CMD,
    ADDR2,
    ADDR1,
    ADDR0,
`ifdef SPI_FLASH_FAST_READ_EN
    DUMMY,
`endif
    PRIME,
    READ,
    TAIL,
    CS_HOLD
  } state_t;

  // Sub-steps of every byte-transfer state: issue strobe, strobe high,
  // mandatory gap cycle, then wait for the engine to go idle.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_STROBE,
    PH_GAP,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/spi_flash_reader_if.sv
// rtl/spi_flash_reader_if.sv - chip select and byte-engine strobe bus between the reader and the SPI byte engine
interface spi_flash_reader_if;

  logic       flash_cs_n;
  logic       spi_enviar;
  logic       spi_recibir;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx;
  logic       spi_busy;

  modport master (
    output flash_cs_n,
    output spi_enviar,
    output spi_recibir,
    output spi_tx,
    input  spi_rx,
    input  spi_busy
  );

  modport slave (
    input  flash_cs_n,
    input  spi_enviar,
    input  spi_recibir,
    input  spi_tx,
    output spi_rx,
    output spi_busy
  );

endinterface

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI flash burst read sequencer driving an external byte engine (option macro: SPI_FLASH_FAST_READ_EN)
module spi_flash_reader
  import spi_flash_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [23:0]         addr,
  input  logic [15:0]         len,
  input  logic                sink_ready,
  output logic                busy,
  output logic                done,
  output logic [7:0]          data_out,
  output logic                data_valid,
  spi_flash_reader_if.master  spi
);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [1:0]  wait_q, wait_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flash_cs_n_q, flash_cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        data_valid_q, data_valid_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        spi_enviar_q, spi_enviar_d;
  logic        spi_recibir_q, spi_recibir_d;
  logic [7:0]  spi_tx_q, spi_tx_d;

  logic        is_recv;
  logic [7:0]  send_byte;
  state_t      next_state;

  // Per-state byte to send and successor for the byte-transfer states.
  always_comb begin
    is_recv    = (state_q == PRIME) || (state_q == READ);
    send_byte  = DUMMY_BYTE;
    next_state = state_q;
    case (state_q)
      CMD:   begin send_byte = READ_OPCODE;    next_state = ADDR2; end
      ADDR2: begin send_byte = addr_q[23:16];  next_state = ADDR1; end
      ADDR1: begin send_byte = addr_q[15:8];   next_state = ADDR0; end
`ifdef SPI_FLASH_FAST_READ_EN
      ADDR0: begin send_byte = addr_q[7:0];    next_state = DUMMY; end
      DUMMY: begin send_byte = DUMMY_BYTE;     next_state = PRIME; end
`else
      ADDR0: begin send_byte = addr_q[7:0];    next_state = PRIME; end
`endif
      PRIME: next_state = READ;
      default: ;
    endcase
  end

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    wait_d        = wait_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    flash_cs_n_d  = flash_cs_n_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    data_valid_d  = 1'b0;
    data_out_d    = data_out_q;
    spi_enviar_d  = 1'b0;
    spi_recibir_d = 1'b0;
    spi_tx_d      = spi_tx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = addr;
          cnt_d  = len;
          if (len != 16'd0) begin
            state_d      = CS_SETUP;
            flash_cs_n_d = 1'b0;
            busy_d       = 1'b1;
            wait_d       = 2'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      CS_SETUP: begin
        if (wait_q == 2'(CS_SETUP_CYCLES - 1)) begin
          wait_d  = 2'd0;
          state_d = CMD;
          phase_d = PH_ISSUE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      // The trailing dummy transfer started by the last read strobe must
      // finish before CS may rise.
      TAIL: begin
        if (!spi.spi_busy) begin
          state_d      = CS_HOLD;
          flash_cs_n_d = 1'b1;
          wait_d       = 2'd0;
        end
      end

      CS_HOLD: begin
        if (wait_q == 2'(CS_HOLD_CYCLES - 1)) begin
          wait_d  = 2'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      // CMD, address, dummy, PRIME and READ all share one strobe handshake.
      default: begin
        case (phase_q)
          PH_ISSUE: begin
            if (!spi.spi_busy && (!is_recv || sink_ready)) begin
              phase_d       = PH_STROBE;
              spi_enviar_d  = !is_recv;
              spi_recibir_d = is_recv;
              spi_tx_d      = is_recv ? DUMMY_BYTE : send_byte;
            end
          end
          PH_STROBE: phase_d = PH_GAP;
          PH_GAP: begin
            phase_d = PH_WAIT;
            // The engine presents the previous transfer's byte now.
            if (state_q == READ) begin
              data_out_d   = spi.spi_rx;
              data_valid_d = 1'b1;
              cnt_d        = cnt_q - 16'd1;
            end
          end
          PH_WAIT: begin
            if (state_q == READ && cnt_q == 16'd0) begin
              state_d = TAIL;
              phase_d = PH_ISSUE;
            end else if (!spi.spi_busy) begin
              phase_d = PH_ISSUE;
              state_d = next_state;
            end
          end
          default: phase_d = PH_ISSUE;
        endcase
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= PH_ISSUE;
      wait_q        <= 2'd0;
      addr_q        <= 24'd0;
      cnt_q         <= 16'd0;
      flash_cs_n_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      data_out_q    <= 8'h00;
      spi_enviar_q  <= 1'b0;
      spi_recibir_q <= 1'b0;
      spi_tx_q      <= 8'hFF;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      wait_q        <= wait_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      flash_cs_n_q  <= flash_cs_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      data_valid_q  <= data_valid_d;
      data_out_q    <= data_out_d;
      spi_enviar_q  <= spi_enviar_d;
      spi_recibir_q <= spi_recibir_d;
      spi_tx_q      <= spi_tx_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign data_valid      = data_valid_q;
  assign data_out        = data_out_q;
  assign spi.flash_cs_n  = flash_cs_n_q;
  assign spi.spi_enviar  = spi_enviar_q;
  assign spi.spi_recibir = spi_recibir_q;
  assign spi.spi_tx      = spi_tx_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed bench for spi_flash_reader with a byte-engine and flash model
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] addr = 24'd0;
  logic [15:0] len = 16'd0;
  logic        sink_ready = 1'b1;
  logic        busy, done, data_valid;
  logic [7:0]  data_out;

  spi_flash_reader_if bus ();

  spi_flash_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .sink_ready (sink_ready),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .data_valid (data_valid),
    .spi        (bus)
  );

  always #5 clk = ~clk;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int         EXP_MOSI_LEN = 5;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int         EXP_MOSI_LEN = 4;
`endif

  // Byte engine + flash model: 4-cycle transfers; dout returns the byte of
  // the previous transfer; flash returns addr[7:0]+offset+0x5B per byte.
  logic [7:0]  eng_dout = 8'h00;
  logic [7:0]  eng_last_rx = 8'hFF;
  logic [7:0]  eng_tx = 8'hFF;
  logic        eng_send = 1'b0;
  logic [2:0]  eng_cnt = 3'd0;
  int          xfer_idx = 0;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_addr = 24'd0;
  logic [7:0]  mosi_log[$];

  assign bus.spi_rx   = eng_dout;
  assign bus.spi_busy = (eng_cnt != 3'd0);

  function automatic logic [7:0] miso_for(int idx);
    int         first;
    logic [7:0] off;
    first = (f_cmd == 8'h0B) ? 5 : 4;
    if (idx < first) return 8'hFF;
    off = 8'(idx - first);
    return f_addr[7:0] + off + 8'h5B;
  endfunction

  always @(posedge clk) begin
    if (bus.spi_enviar || bus.spi_recibir) begin
      eng_dout <= eng_last_rx;
      eng_cnt  <= 3'd4;
      eng_tx   <= bus.spi_enviar ? bus.spi_tx : 8'hFF;
      eng_send <= bus.spi_enviar;
    end else if (eng_cnt != 3'd0) begin
      eng_cnt <= eng_cnt - 3'd1;
      if (eng_cnt == 3'd1 && !bus.flash_cs_n) begin
        eng_last_rx <= miso_for(xfer_idx);
        if (eng_send) mosi_log.push_back(eng_tx);
        case (xfer_idx)
          0: f_cmd <= eng_tx;
          1: f_addr[23:16] <= eng_tx;
          2: f_addr[15:8] <= eng_tx;
          3: f_addr[7:0] <= eng_tx;
          default: ;
        endcase
        xfer_idx <= xfer_idx + 1;
      end
    end
    if (bus.flash_cs_n) xfer_idx <= 0;
  end

  // Protocol monitor sampled on the falling edge.
  logic [7:0] rx_q[$];
  int done_cnt = 0, viol = 0, cs_falls = 0, strobe_cnt = 0;
  logic prev_sink = 1'b1, prev_en = 1'b0, prev_rc = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        rx_q.push_back(data_out);
        if (bus.flash_cs_n) viol++;
      end
      if (done) done_cnt++;
      if (prev_cs && !bus.flash_cs_n) cs_falls++;
      if (bus.spi_enviar || bus.spi_recibir) strobe_cnt++;
      if ((bus.spi_enviar || bus.spi_recibir) && bus.flash_cs_n) viol++;
      if ((bus.spi_enviar && prev_en) || (bus.spi_recibir && prev_rc)) viol++;
      if (bus.spi_enviar && bus.spi_recibir) viol++;
      if (bus.spi_recibir && !prev_sink) viol++;
    end
    prev_sink = sink_ready;
    prev_en   = bus.spi_enviar;
    prev_rc   = bus.spi_recibir;
    prev_cs   = bus.flash_cs_n;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    mosi_log.delete();
    done_cnt   = 0;
    viol       = 0;
    cs_falls   = 0;
    strobe_cnt = 0;
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    logic [7:0]  first;
    logic [7:0]  last;
  } vec_t;

  // Runs one burst; optionally pulses a conflicting start at negedge 'poke'.
  task automatic run_vec(input vec_t v, input int poke);
    logic [7:0] e;
    clear_obs();
    @(posedge clk); #1;
    addr = v.addr; len = v.len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0) check("busy_after_start", busy, 1'b1);
      if (c == poke) begin
        start = 1'b1; addr = 24'hABCDEF; len = 16'd1;
      end else if (c == poke + 1) begin
        start = 1'b0;
      end
      if (done_cnt != 0) break;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("byte_count", rx_q.size(), 32'(v.len));
    for (int i = 0; i < int'(v.len); i++) begin
      if (i < rx_q.size()) begin
        e = v.first + 8'(i);
        check($sformatf("byte%0d", i), rx_q[i], e);
      end
    end
    if (rx_q.size() != 0) check("last_byte", rx_q[rx_q.size()-1], v.last);
    check("cs_falls", cs_falls, 1);
    check("protocol_viol", viol, 0);
    check("cs_high_end", bus.flash_cs_n, 1'b1);
    check("busy_low_end", busy, 1'b0);
    check("mosi_len", mosi_log.size(), EXP_MOSI_LEN);
    if (mosi_log.size() >= 4) begin
      check("mosi_cmd", mosi_log[0], EXP_CMD);
      check("mosi_a2", mosi_log[1], v.addr[23:16]);
      check("mosi_a1", mosi_log[2], v.addr[15:8]);
      check("mosi_a0", mosi_log[3], v.addr[7:0]);
    end
    if (mosi_log.size() >= 5) check("mosi_dummy", mosi_log[4], 8'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    bit   found;
    int   stall_dv;
    vecs[0] = '{24'h012345, 16'd4, 8'hA0, 8'hA3};
    vecs[1] = '{24'hABCDEF, 16'd1, 8'h4A, 8'h4A};
    vecs[2] = '{24'h0000FE, 16'd3, 8'h59, 8'h5B};
    vecs[3] = '{24'h000010, 16'd2, 8'h6B, 8'h6C};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus.flash_cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dv", data_valid, 1'b0);
    check("rst_enviar", bus.spi_enviar, 1'b0);
    check("rst_recibir", bus.spi_recibir, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_spi_tx", bus.spi_tx, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven bursts
    for (int k = 0; k < 4; k++) run_vec(vecs[k], -10);

    // len = 0: done one cycle later, no CS, no strobes
    clear_obs();
    @(posedge clk); #1;
    addr = 24'h123456; len = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    @(negedge clk);
    check("len0_done_once", done, 1'b0);
    repeat (10) @(negedge clk);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_cs_falls", cs_falls, 0);
    check("len0_strobes", strobe_cnt, 0);

    // Consumer stall after first byte
    clear_obs();
    @(posedge clk); #1;
    addr = 24'h000100; len = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (data_valid) begin found = 1'b1; break; end
    end
    check("stall_first_byte_seen", found, 1'b1);
    sink_ready = 1'b0;
    stall_dv = 0;
    repeat (50) begin
      @(negedge clk);
      if (data_valid) stall_dv++;
    end
    check("stall_no_bytes", stall_dv, 0);
    sink_ready = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    repeat (2) @(negedge clk);
    check("stall_done", done_cnt, 1);
    check("stall_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("stall_b0", rx_q[0], 8'h5B);
      check("stall_b1", rx_q[1], 8'h5C);
      check("stall_b2", rx_q[2], 8'h5D);
    end
    check("stall_viol", viol, 0);

    // Reset during ADDR1, then a normal burst
    clear_obs();
    @(posedge clk); #1;
    addr = 24'h012345; len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus.spi_enviar && bus.spi_tx == 8'h23) begin found = 1'b1; break; end
    end
    check("addr1_reached", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cs_n", bus.flash_cs_n, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    repeat (30) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_no_bytes", rx_q.size(), 0);
    run_vec(vecs[0], -10);

    // Conflicting start mid-burst is ignored
    run_vec(vecs[0], 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
